aes_round_seq: RTL

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_seq_pkg.sv | 28 ++
 rtl/aes_seq_wdog.sv | 35 +++
 rtl/aes_round_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_seq_pkg;

  // Sequencer states: one per sub-operation plus idle and a one-cycle finish.
  typedef enum logic [2:0] {
    StIdle,
    StArk,
    StSb,
    StSr,
    StMc,
    StFin
  } seq_state_e;

  // Legal round counts for AES-128/192/256.
  localparam logic [3:0] NrAes128  = 4'd10;
  localparam logic [3:0] NrAes192  = 4'd12;
  localparam logic [3:0] NrAes256  = 4'd14;
  localparam logic [3:0] NrDefault = NrAes128;

  // Anything other than a legal round count falls back to AES-128.
  function automatic logic [3:0] legal_nr(input logic [3:0] nr);
    if (nr == NrAes128 || nr == NrAes192 || nr == NrAes256) begin
      return nr;
    end
    return NrDefault;
  endfunction

endpackage

// File: rtl/aes_seq_wdog.sv
// Sub-operation watchdog: raises timeout when one sub-operation has been
// running for TIMEOUT_CYCLES cycles without its done.
module aes_seq_wdog
  import aes_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic run,
  input  logic op_done,
  output logic timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // cnt_q holds (cycles already spent in the current sub-operation) - 1 at the
  // last allowed cycle, so expiry lands exactly on cycle TIMEOUT_CYCLES.
  assign timeout = run && !op_done && (cnt_q == CntLast);

  // Any exit from the current sub-operation (done, expiry, not running) restarts the count.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt_q <= '0;
    end else if (!run || op_done || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/aes_round_seq.sv
// AES round sequencer: walks AddRoundKey / SubBytes / ShiftRows / MixColumns
// sub-blocks through Nr rounds for one block per ap_start.
// Optional watchdog enabled by defining ROUND_TIMEOUT_EN.
module aes_round_seq
  import aes_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       ap_clk,
  input  logic       ap_rst,
  input  logic       ap_start,
  output logic       ap_done,
  output logic       ap_idle,
  output logic       ap_ready,
  input  logic [3:0] nb_rounds,
  output logic       ark_start,
  output logic       sb_start,
  output logic       sr_start,
  output logic       mc_start,
  input  logic       ark_done,
  input  logic       sb_done,
  input  logic       sr_done,
  input  logic       mc_done,
  output logic [5:0] ark_n,
  output logic [3:0] round_cnt,
  output logic       err
);

  if (TIMEOUT_CYCLES == 0) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_e state_q;
  logic [3:0] nr_q;
  logic [3:0] round_cnt_q;
  logic [5:0] ark_n_q;
  logic       ark_start_q, sb_start_q, sr_start_q, mc_start_q;
  logic       done_q;
  logic       idle_q;
  logic       op_done;
  logic       timeout;

  // Done of the sub-block currently being driven; the others are ignored.
  always_comb begin
    op_done = 1'b0;
    unique case (state_q)
      StArk:   op_done = ark_done;
      StSb:    op_done = sb_done;
      StSr:    op_done = sr_done;
      StMc:    op_done = mc_done;
      default: op_done = 1'b0;
    endcase
  end

  // Sequencer FSM; starts, ark_n, done and idle are registered alongside the state.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      nr_q        <= NrDefault;
      round_cnt_q <= '0;
      ark_n_q     <= '0;
      ark_start_q <= 1'b0;
      sb_start_q  <= 1'b0;
      sr_start_q  <= 1'b0;
      mc_start_q  <= 1'b0;
      done_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      ark_start_q <= 1'b0;
      sb_start_q  <= 1'b0;
      sr_start_q  <= 1'b0;
      mc_start_q  <= 1'b0;
      ark_n_q     <= '0;
      done_q      <= 1'b0;
      idle_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ap_start) begin
            nr_q        <= legal_nr(nb_rounds);
            round_cnt_q <= '0;
            state_q     <= StArk;
            ark_start_q <= 1'b1;
          end else begin
            idle_q <= 1'b1;
          end
        end
        StArk: begin
          if (op_done) begin
            if (round_cnt_q < nr_q) begin
              state_q    <= StSb;
              sb_start_q <= 1'b1;
            end else begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end
          end else if (timeout) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else begin
            ark_start_q <= 1'b1;
            ark_n_q     <= {2'b00, round_cnt_q};
          end
        end
        StSb: begin
          if (op_done) begin
            state_q     <= StSr;
            sr_start_q  <= 1'b1;
            round_cnt_q <= round_cnt_q + 4'd1;
          end else if (timeout) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else begin
            sb_start_q <= 1'b1;
          end
        end
        StSr: begin
          if (op_done) begin
            if (round_cnt_q < nr_q) begin
              state_q    <= StMc;
              mc_start_q <= 1'b1;
            end else begin
              // Final round skips MixColumns.
              state_q     <= StArk;
              ark_start_q <= 1'b1;
              ark_n_q     <= {2'b00, round_cnt_q};
            end
          end else if (timeout) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else begin
            sr_start_q <= 1'b1;
          end
        end
        StMc: begin
          if (op_done) begin
            state_q     <= StArk;
            ark_start_q <= 1'b1;
            ark_n_q     <= {2'b00, round_cnt_q};
          end else if (timeout) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else begin
            mc_start_q <= 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          idle_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef ROUND_TIMEOUT_EN
  logic op_active;
  logic err_q;

  assign op_active = state_q inside {StArk, StSb, StSr, StMc};

  aes_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .run    (op_active),
    .op_done(op_done),
    .timeout(timeout)
  );

  // Sticky timeout flag, cleared only when a new block is accepted.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end else if (state_q == StIdle && ap_start) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign ap_done   = done_q;
  assign ap_ready  = done_q;
  assign ap_idle   = idle_q;
  assign ark_start = ark_start_q;
  assign sb_start  = sb_start_q;
  assign sr_start  = sr_start_q;
  assign mc_start  = mc_start_q;
  assign ark_n     = ark_n_q;
  assign round_cnt = round_cnt_q;

endmodule
